// File: rtl/ram16_buffer.sv
`default_nettype none
// ============================================================================
// Module   : ram16_buffer
// Purpose  : Single-port synchronous RAM of 16-bit words, 2**ADDR_WIDTH deep.
//            Keeps a bitmap of the words written since the last reset or clear
//            and raises FULL once every word holds data. A one-cycle CLR zeroes
//            the array and the bitmap so the buffer can be filled again.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK   in   1           clock, rising edge
//   RST   in   1           asynchronous active-high reset
//   EN    in   1           port enable; no read or write while low
//   WE    in   1           write enable, qualified by EN
//   CLR   in   1           synchronous clear of the whole array, ignores EN
//   FULL  out  1           every word written since the last reset/clear
//   A     in   ADDR_WIDTH  word address
//   Di    in   16          write data
//   Do    out  16          registered read data, one cycle latency
// ----------------------------------------------------------------------------
// Configuration macro
//   RAM16_WRITE_THROUGH_EN : defined   -> write-first port, Do <= Di on writes
//                            undefined -> no-change port, Do holds on writes
// Priority on each rising edge: CLR > write > read > hold.
// ============================================================================
module ram16_buffer #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic                  WE,
    input  logic                  CLR,
    output logic                  FULL,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [15:0]           Di,
    output logic [15:0]           Do
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Storage array; the name is kept plain so benches can dump it.
    logic [15:0]      RAM [0:DEPTH-1];

    // One bit per word: set when the word is written, cleared by reset/clear.
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] valid_d;

    // Read-data register.
    logic [15:0]      do_q;
    logic [15:0]      do_d;

    logic             wr_en;
    logic             rd_en;

    assign wr_en = EN & WE & ~CLR;
    assign rd_en = EN & ~WE & ~CLR;

    // ------------------------------------------------------------------
    // Next-state for the bitmap and read register
    // ------------------------------------------------------------------
    always_comb begin
        valid_d = valid;
        do_d    = do_q;
        if (CLR) begin
            valid_d = '0;
            do_d    = '0;
        end else if (wr_en) begin
            valid_d[A] = 1'b1;
`ifdef RAM16_WRITE_THROUGH_EN
            do_d       = Di;
`else
            do_d       = do_q;
`endif
        end else if (rd_en) begin
            do_d = RAM[A];
        end
    end

    // ------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                RAM[i] <= '0;
            end
        end else if (CLR) begin
            // A write presented together with CLR is dropped.
            for (int i = 0; i < DEPTH; i++) begin
                RAM[i] <= '0;
            end
        end else if (wr_en) begin
            RAM[A] <= Di;
        end
    end

    // ------------------------------------------------------------------
    // Bitmap and read register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid <= '0;
            do_q  <= '0;
        end else begin
            valid <= valid_d;
            do_q  <= do_d;
        end
    end

    // FULL comes straight from the registered bitmap, so it rises after the
    // edge that writes the last unwritten word and falls after a clear edge.
    assign FULL = &valid;
    assign Do   = do_q;

endmodule
`default_nettype wire

// File: tb/tb_ram16_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram16_buffer
// Purpose  : Directed self-checking bench for ram16_buffer at ADDR_WIDTH=2.
//            Expected values are written by hand; the read-data expectation
//            on writes depends on RAM16_WRITE_THROUGH_EN.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ram16_buffer;

    logic        CLK;
    logic        RST;
    logic        EN;
    logic        WE;
    logic        CLR;
    logic        FULL;
    logic [1:0]  A;
    logic [15:0] Di;
    logic [15:0] Do;

    int total;
    int bad;

    ram16_buffer #(.ADDR_WIDTH(2)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .WE   (WE),
        .CLR  (CLR),
        .FULL (FULL),
        .A    (A),
        .Di   (Di),
        .Do   (Do)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given controls; outputs sampled 1ns after the edge.
    task automatic cyc(input logic en, input logic we, input logic clr,
                       input logic [1:0] a, input logic [15:0] d);
        EN  = en;
        WE  = we;
        CLR = clr;
        A   = a;
        Di  = d;
        @(posedge CLK);
        #1;
        EN  = 1'b0;
        WE  = 1'b0;
        CLR = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        cyc(1'b1, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [1:0] a);
        cyc(1'b1, 1'b0, 1'b0, a, 16'h0000);
    endtask

    // Read data expected right after a write, given Do before the write.
    function automatic logic [15:0] wdo(input logic [15:0] prev, input logic [15:0] d);
`ifdef RAM16_WRITE_THROUGH_EN
        return d;
`else
        return prev;
`endif
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        EN = 1'b0; WE = 1'b0; CLR = 1'b0; A = 2'd0; Di = 16'h0000;

        // Reset for two cycles.
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_do", Do, 16'h0000);
        check("rst_full", {15'd0, FULL}, 16'h0000);
        RST = 1'b0;
        for (int i = 0; i < 4; i++) check($sformatf("rst_ram%0d", i), dut.RAM[i], 16'h0000);

        // Single write then read back.
        wr(2'd0, 16'h0001);
        check("w0_do", Do, wdo(16'h0000, 16'h0001));
        rd(2'd0);
        check("r0_do", Do, 16'h0001);
        check("r0_full", {15'd0, FULL}, 16'h0000);

        // Fill all four words.
        wr(2'd0, 16'h0001);
        wr(2'd1, 16'h0002);
        wr(2'd2, 16'h0003);
        check("fill3_full", {15'd0, FULL}, 16'h0000);
        wr(2'd3, 16'h0004);
        check("fill4_full", {15'd0, FULL}, 16'h0001);
        check("fill4_do", Do, wdo(16'h0001, 16'h0004));
        rd(2'd3);
        check("r3_do", Do, 16'h0004);

        // Rewriting a valid word keeps FULL; idle cycle ignores WE.
        wr(2'd1, 16'h0022);
        check("rew_full", {15'd0, FULL}, 16'h0001);
        check("rew_ram1", dut.RAM[1], 16'h0022);
        cyc(1'b0, 1'b1, 1'b0, 2'd2, 16'hFFFF);
        check("idle_ram2", dut.RAM[2], 16'h0003);
        check("idle_do", Do, wdo(16'h0004, 16'h0022));

        // Clear while full.
        cyc(1'b0, 1'b0, 1'b1, 2'd0, 16'h0000);
        check("clr_full", {15'd0, FULL}, 16'h0000);
        check("clr_do", Do, 16'h0000);
        for (int i = 0; i < 4; i++) check($sformatf("clr_ram%0d", i), dut.RAM[i], 16'h0000);

        // Refill with 5..8.
        wr(2'd0, 16'h0005);
        wr(2'd1, 16'h0006);
        wr(2'd2, 16'h0007);
        check("refill3_full", {15'd0, FULL}, 16'h0000);
        wr(2'd3, 16'h0008);
        check("refill4_full", {15'd0, FULL}, 16'h0001);
        check("refill_ram2", dut.RAM[2], 16'h0007);

        // CLR beats a concurrent write.
        cyc(1'b1, 1'b1, 1'b1, 2'd2, 16'hBEEF);
        check("clrw_ram2", dut.RAM[2], 16'h0000);
        check("clrw_valid2", {15'd0, dut.valid[2]}, 16'h0000);
        check("clrw_full", {15'd0, FULL}, 16'h0000);

        // Hammering one address never fills the buffer.
        wr(2'd1, 16'h0011);
        wr(2'd1, 16'h0012);
        wr(2'd1, 16'h0013);
        wr(2'd1, 16'h0014);
        check("ham_full", {15'd0, FULL}, 16'h0000);
        rd(2'd1);
        check("ham_do", Do, 16'h0014);

        // Reset in the middle of a fill.
        cyc(1'b0, 1'b0, 1'b1, 2'd0, 16'h0000);
        wr(2'd0, 16'h0011);
        wr(2'd1, 16'h0022);
        wr(2'd2, 16'h0033);
        rd(2'd0);
        check("mid_do", Do, 16'h0011);
        #2;
        RST = 1'b1;
        #1;
        check("arst_do", Do, 16'h0000);
        check("arst_full", {15'd0, FULL}, 16'h0000);
        check("arst_ram0", dut.RAM[0], 16'h0000);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        wr(2'd0, 16'h0101);
        wr(2'd1, 16'h0202);
        wr(2'd2, 16'h0303);
        check("post3_full", {15'd0, FULL}, 16'h0000);
        wr(2'd3, 16'h0404);
        check("post4_full", {15'd0, FULL}, 16'h0001);

        // Write-through behaviour on a fresh write after a known read.
        rd(2'd1);
        check("pre_wt_do", Do, 16'h0202);
        wr(2'd0, 16'h00AA);
        check("wt_do", Do, wdo(16'h0202, 16'h00AA));
        rd(2'd0);
        check("wt_rd", Do, 16'h00AA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
